// File: rtl/fft_r22sdf_pkg.sv
// fft_r22sdf_pkg: shared definitions for the R2^2SDF front-end sequencer
//   state_t     : sequencer states (IDLE, RUN, FLUSH)
//   clog2       : ceil(log2(v)) for sizing counters at elaboration
//   bit_reverse : reverses the low w bits of v (natural-order bin index)
package fft_r22sdf_pkg;

   typedef enum logic [1:0] {ST_IDLE, ST_RUN, ST_FLUSH} state_t;

   function automatic int clog2(input int v);
      int r;
      r = 0;
      while ((1 << r) < v) r++;
      return r;
   endfunction

   function automatic logic [31:0] bit_reverse(input logic [31:0] v, input int w);
      logic [31:0] r;
      r = '0;
      for (int i = 0; i < w; i++) r[i] = v[w-1-i];
      return r;
   endfunction

endpackage

// File: rtl/fft_r22sdf_tag_delay.sv
// fft_r22sdf_tag_delay: delays the real/filler sample tag by the pipeline latency
//   clk_i       : clock
//   rst_n       : synchronous active-low reset, discards every tag in the line
//   tag_i       : tag aligned to the pipeline input sample
//   tag_o       : tag aligned to the pipeline output (tag_i delayed PIPE_LAT)
//   in_flight_o : number of real tags currently held in the line
module fft_r22sdf_tag_delay
   import fft_r22sdf_pkg::*;
#(
   parameter int PIPE_LAT = 1033,
   parameter int IFW      = clog2(PIPE_LAT + 1)
) (
   input  logic           clk_i,
   input  logic           rst_n,
   input  logic           tag_i,
   output logic           tag_o,
   output logic [IFW-1:0] in_flight_o
);

   shift_reg #(.WIDTH(1), .DEPTH(PIPE_LAT)) u_line (
      .clk_i (clk_i),
      .rst_n (rst_n),
      .d_i   (tag_i),
      .q_o   (tag_o)
   );

   // Counts set bits of the line: tag_i enters and tag_o leaves on the same edge.
   always_ff @(posedge clk_i) begin
      if (!rst_n) in_flight_o <= '0;
      else        in_flight_o <= in_flight_o + IFW'(tag_i) - IFW'(tag_o);
   end

endmodule

// File: rtl/shift_reg.sv
// shift_reg: generic DEPTH-stage register line with synchronous active-low clear
//   clk_i : clock
//   rst_n : synchronous active-low reset, clears every stage
//   d_i   : value shifted into stage 0 each cycle
//   q_o   : value leaving the last stage (d_i delayed DEPTH cycles)
module shift_reg #(
   parameter int WIDTH = 1,
   parameter int DEPTH = 1
) (
   input  logic             clk_i,
   input  logic             rst_n,
   input  logic [WIDTH-1:0] d_i,
   output logic [WIDTH-1:0] q_o
);

   logic [WIDTH-1:0] sr [DEPTH];

   always_ff @(posedge clk_i) begin
      if (!rst_n) begin
         for (int i = 0; i < DEPTH; i++) sr[i] <= '0;
      end else begin
         sr[0] <= d_i;
         for (int i = 1; i < DEPTH; i++) sr[i] <= sr[i-1];
      end
   end

   assign q_o = sr[DEPTH-1];

endmodule

// File: rtl/fft_r22sdf_ctrl.sv
// fft_r22sdf_ctrl: front-end sequencer feeding the single-path R2^2SDF FFT pipeline
//   clk_i, rst_n           : clock, synchronous active-low reset
//   s_valid_i/s_ready_o    : input sample handshake
//   s_re_i, s_im_i         : signed input sample
//   pipe_cnt_o             : free-running sample counter to the first stage
//   pipe_re_o, pipe_im_o   : sample (or zero fill) to the first stage
//   m_valid_o              : pipeline output holds a real bin
//   m_idx_o                : natural-order bin index of the current output
//   m_last_o               : final bin of a frame
//   busy_o                 : sequencer not idle
//   err_o                  : sticky, input dropped mid-frame
module fft_r22sdf_ctrl
   import fft_r22sdf_pkg::*;
#(
   parameter int DATA_WIDTH = 25,
   parameter int FFT_N      = 1024,
   parameter int FFT_NLOG2  = 10,
   parameter int PIPE_LAT   = 1033
) (
   input  logic                        clk_i,
   input  logic                        rst_n,
   input  logic                        s_valid_i,
   output logic                        s_ready_o,
   input  logic signed [DATA_WIDTH-1:0] s_re_i,
   input  logic signed [DATA_WIDTH-1:0] s_im_i,
   output logic [FFT_NLOG2-1:0]        pipe_cnt_o,
   output logic signed [DATA_WIDTH-1:0] pipe_re_o,
   output logic signed [DATA_WIDTH-1:0] pipe_im_o,
   output logic                        m_valid_o,
   output logic [FFT_NLOG2-1:0]        m_idx_o,
   output logic                        m_last_o,
   output logic                        busy_o,
   output logic                        err_o
);

   localparam int                   IFW     = clog2(PIPE_LAT + 1);
   localparam logic [FFT_NLOG2-1:0] CNT_MAX = FFT_NLOG2'(FFT_N - 1);

   state_t               state, state_nxt;
   logic                 started, pipe_tag;
   logic                 nxt_zero, accept, tag_nxt, err_set;
   logic [FFT_NLOG2-1:0] cnt_nxt, out_cnt;
   logic [IFW-1:0]       in_flight;

   // Counter holds at 0 until the first accept, then never pauses.
   assign cnt_nxt  = !started ? '0 : (pipe_cnt_o == CNT_MAX) ? '0 : pipe_cnt_o + FFT_NLOG2'(1);
   assign nxt_zero = (cnt_nxt == '0);

   always_ff @(posedge clk_i) begin
      if (!rst_n) state <= ST_IDLE;
      else        state <= state_nxt;
   end

   always_comb begin
      state_nxt = state;
      case (state)
         ST_IDLE:  if (accept) state_nxt = ST_RUN;
         ST_RUN:   if (!s_valid_i && nxt_zero) state_nxt = ST_FLUSH;
         ST_FLUSH: if (in_flight == '0) state_nxt = ST_IDLE;
         default:  state_nxt = ST_IDLE;
      endcase
   end

   // A gap inside a frame still issues a real (zero) sample so the frame
   // stays whole; a gap at a frame boundary issues filler and ends the run.
   always_comb begin
      s_ready_o = (state == ST_RUN) | ((state == ST_IDLE) & nxt_zero);
      accept    = s_valid_i & s_ready_o;
      tag_nxt   = accept | ((state == ST_RUN) & !nxt_zero);
      err_set   = (state == ST_RUN) & !s_valid_i & !nxt_zero;
   end

   always_ff @(posedge clk_i) begin
      if (!rst_n) begin
         started    <= 1'b0;
         pipe_cnt_o <= '0;
         pipe_re_o  <= '0;
         pipe_im_o  <= '0;
         pipe_tag   <= 1'b0;
         err_o      <= 1'b0;
         out_cnt    <= '0;
      end else begin
         started    <= started | accept;
         pipe_cnt_o <= cnt_nxt;
         pipe_re_o  <= accept ? s_re_i : '0;
         pipe_im_o  <= accept ? s_im_i : '0;
         pipe_tag   <= tag_nxt;
         err_o      <= err_o | err_set;
         out_cnt    <= !m_valid_o ? out_cnt : (out_cnt == CNT_MAX) ? '0 : out_cnt + FFT_NLOG2'(1);
      end
   end

   fft_r22sdf_tag_delay #(.PIPE_LAT(PIPE_LAT), .IFW(IFW)) u_tag (
      .clk_i       (clk_i),
      .rst_n       (rst_n),
      .tag_i       (pipe_tag),
      .tag_o       (m_valid_o),
      .in_flight_o (in_flight)
   );

   assign m_idx_o  = FFT_NLOG2'(bit_reverse(32'(out_cnt), FFT_NLOG2));
   assign m_last_o = m_valid_o & (out_cnt == CNT_MAX);
   assign busy_o   = (state != ST_IDLE);

endmodule

// File: tb/tb_fft_r22sdf_ctrl.sv
// tb_fft_r22sdf_ctrl: self-checking bench for the FFT front-end sequencer
module tb_fft_r22sdf_ctrl;

   localparam int DW = 25, N = 16, NL = 4, LAT = 20;

   logic                 clk_i = 1'b0, rst_n = 1'b0, s_valid_i = 1'b0;
   logic signed [DW-1:0] s_re_i = '0, s_im_i = '0;
   logic                 s_ready_o, m_valid_o, m_last_o, busy_o, err_o;
   logic [NL-1:0]        pipe_cnt_o, m_idx_o;
   logic signed [DW-1:0] pipe_re_o, pipe_im_o;

   fft_r22sdf_ctrl #(.DATA_WIDTH(DW), .FFT_N(N), .FFT_NLOG2(NL), .PIPE_LAT(LAT)) dut (
      .clk_i(clk_i), .rst_n(rst_n), .s_valid_i(s_valid_i), .s_ready_o(s_ready_o),
      .s_re_i(s_re_i), .s_im_i(s_im_i), .pipe_cnt_o(pipe_cnt_o), .pipe_re_o(pipe_re_o),
      .pipe_im_o(pipe_im_o), .m_valid_o(m_valid_o), .m_idx_o(m_idx_o), .m_last_o(m_last_o),
      .busy_o(busy_o), .err_o(err_o)
   );

   always #5 clk_i = ~clk_i;

   int checks = 0, errors = 0, ncyc = 0;
   int nmv, nlast, first_mv, last_mv, busy_fall;
   int idxs[$];
   bit prev_busy = 1'b0;

   task automatic chk(input string nm, input int act, input int exp);
      checks++;
      if (act != exp) begin
         errors++;
         $display("FAIL %s: got %0d, want %0d (cycle %0d)", nm, act, exp, ncyc);
      end
   endtask

   // Reference model: sequencer mode, frame position and a history of issued
   // tags; output validity is the tag history LAT cycles back.
   int m_st, m_cnt, m_re, m_im, m_out, m_inflight;
   bit m_started, m_err, m_valid;
   bit tq[$];

   function automatic int brev(input int v);
      int r = 0;
      for (int k = 0; k < NL; k++) begin
         r = r * 2 + v % 2;
         v = v / 2;
      end
      return r;
   endfunction

   function automatic void m_reset();
      m_st = 0; m_cnt = 0; m_re = 0; m_im = 0; m_out = 0; m_inflight = 0;
      m_started = 0; m_err = 0; m_valid = 0;
      tq.delete();
      for (int k = 0; k < LAT; k++) tq.push_back(1'b0);
   endfunction

   function automatic bit m_ready();
      bit nxt0 = !m_started || m_cnt == N - 1;
      return m_st == 1 || (m_st == 0 && nxt0);
   endfunction

   function automatic void m_edge(input bit r, input bit v, input int re, input int im);
      bit nxt0, acc, ntag;
      int nmode, nre, nim, sum;
      if (!r) begin
         m_reset();
         return;
      end
      nxt0 = !m_started || m_cnt == N - 1;
      acc = v && m_ready();
      ntag = 0; nre = 0; nim = 0; nmode = m_st;
      if (m_st == 0 && acc) begin
         ntag = 1; nre = re; nim = im; nmode = 1;
      end else if (m_st == 1) begin
         if (v) begin
            ntag = 1; nre = re; nim = im;
         end else if (!nxt0) begin
            ntag = 1; m_err = 1;
         end else nmode = 2;
      end else if (m_st == 2 && m_inflight == 0) nmode = 0;
      m_cnt = m_started ? (m_cnt + 1) % N : 0;
      if (acc) m_started = 1;
      m_out = (m_out + int'(m_valid)) % N;
      sum = 0;
      foreach (tq[k]) sum += int'(tq[k]);
      m_valid = tq[0];
      m_inflight = sum;
      void'(tq.pop_front());
      tq.push_back(ntag);
      m_st = nmode; m_re = nre; m_im = nim;
   endfunction

   task automatic trk_clr();
      nmv = 0; nlast = 0; first_mv = -1; last_mv = -1; busy_fall = -1;
      idxs.delete();
   endtask

   task automatic cyc(input bit r, input bit v, input int re, input int im);
      rst_n = r; s_valid_i = v; s_re_i = DW'(re); s_im_i = DW'(im);
      #1;
      chk("s_ready", int'(s_ready_o), int'(m_ready()));
      @(posedge clk_i);
      #1;
      ncyc++;
      m_edge(r, v, int'(s_re_i), int'(s_im_i));
      chk("pipe_cnt", int'(pipe_cnt_o), m_cnt);
      chk("pipe_re", int'(pipe_re_o), m_re);
      chk("pipe_im", int'(pipe_im_o), m_im);
      chk("m_valid", int'(m_valid_o), int'(m_valid));
      chk("m_idx", int'(m_idx_o), brev(m_out));
      chk("m_last", int'(m_last_o), int'(m_valid && m_out == N - 1));
      chk("busy", int'(busy_o), int'(m_st != 0));
      chk("err", int'(err_o), int'(m_err));
      if (m_valid_o) begin
         nmv++;
         last_mv = ncyc;
         if (first_mv < 0) first_mv = ncyc;
         if (idxs.size() < 4) idxs.push_back(int'(m_idx_o));
      end
      if (m_last_o) nlast++;
      if (prev_busy && !busy_o) busy_fall = ncyc;
      prev_busy = busy_o;
   endtask

   typedef struct {
      bit r; bit v; int re; bit rdy; int cnt; int pre; bit busy; bit err;
   } vec_t;
   vec_t tbl[9];

   initial begin
      #2_000_000;
      $display("FAIL watchdog: simulation did not finish");
      $fatal(1, "watchdog");
   end

   initial begin
      int a0, k, waited;
      int exp_idx[4];
      tbl[0] = '{0, 0, 0, 1, 0, 0, 0, 0};
      tbl[1] = '{1, 0, 0, 1, 0, 0, 0, 0};
      tbl[2] = '{1, 1, 5, 1, 0, 5, 1, 0};
      tbl[3] = '{1, 1, 6, 1, 1, 6, 1, 0};
      tbl[4] = '{1, 1, 7, 1, 2, 7, 1, 0};
      tbl[5] = '{1, 0, 0, 1, 3, 0, 1, 1};
      tbl[6] = '{1, 1, 9, 1, 4, 9, 1, 1};
      tbl[7] = '{0, 1, 3, 1, 0, 0, 0, 0};
      tbl[8] = '{1, 0, 0, 1, 0, 0, 0, 0};
      exp_idx = '{0, 8, 4, 12};

      repeat (2) @(posedge clk_i);
      #1;
      for (int i = 0; i < 9; i++) begin
         rst_n = tbl[i].r; s_valid_i = tbl[i].v;
         s_re_i = DW'(tbl[i].re); s_im_i = DW'(-tbl[i].re);
         #1;
         chk("tbl_ready", int'(s_ready_o), int'(tbl[i].rdy));
         @(posedge clk_i);
         #1;
         chk("tbl_cnt", int'(pipe_cnt_o), tbl[i].cnt);
         chk("tbl_re", int'(pipe_re_o), tbl[i].pre);
         chk("tbl_im", int'(pipe_im_o), -tbl[i].pre);
         chk("tbl_busy", int'(busy_o), int'(tbl[i].busy));
         chk("tbl_err", int'(err_o), int'(tbl[i].err));
         chk("tbl_mvalid", int'(m_valid_o), 0);
      end

      m_reset();
      cyc(0, 0, 0, 0);

      // Two back-to-back frames then drain.
      trk_clr();
      cyc(1, 1, 1, -1);
      a0 = ncyc;
      for (int i = 2; i <= 32; i++) cyc(1, 1, i, -i);
      repeat (60) cyc(1, 0, 0, 0);
      chk("a_first_valid_lat", first_mv - a0, LAT);
      chk("a_nvalid", nmv, 32);
      chk("a_nlast", nlast, 2);
      chk("a_busy_fall", busy_fall - last_mv, 2);
      for (int i = 0; i < 4; i++) chk("a_idx_seq", idxs.size() > i ? idxs[i] : -1, exp_idx[i]);

      // Single-cycle gap at frame position 5.
      trk_clr();
      k = 500;
      for (int i = 0; i < 40; i++) begin
         cyc(1, 1, k, k + 1);
         k++;
         if (busy_o && pipe_cnt_o == 4) break;
      end
      chk("b_sync", int'(pipe_cnt_o), 4);
      cyc(1, 0, 0, 0);
      chk("b_gap_cnt", int'(pipe_cnt_o), 5);
      chk("b_gap_re", int'(pipe_re_o), 0);
      chk("b_err", int'(err_o), 1);
      for (int i = 0; i < 20 && pipe_cnt_o != NL'(N - 1); i++) begin
         cyc(1, 1, k, -k);
         k++;
      end
      repeat (60) cyc(1, 0, 0, 0);
      chk("b_nvalid", nmv, 16);
      chk("b_err_sticky", int'(err_o), 1);

      // Start request at count 7 must wait for frame alignment.
      for (int i = 0; i < 80 && !(pipe_cnt_o == 7 && !busy_o); i++) cyc(1, 0, 0, 0);
      chk("c_sync", int'(pipe_cnt_o), 7);
      waited = 0;
      for (int i = 0; i < 20; i++) begin
         cyc(1, 1, 77, -77);
         waited++;
         if (pipe_re_o == 77) break;
      end
      chk("c_wait", waited, 9);
      chk("c_first_cnt", int'(pipe_cnt_o), 0);

      // Reset mid-frame at count 9.
      for (int i = 0; i < 20 && pipe_cnt_o != 9; i++) cyc(1, 1, 200 + i, 3);
      chk("d_sync", int'(pipe_cnt_o), 9);
      cyc(0, 1, 5, 5);
      chk("d_rst_cnt", int'(pipe_cnt_o), 0);
      chk("d_rst_err", int'(err_o), 0);
      trk_clr();
      repeat (40) cyc(1, 0, 0, 0);
      chk("d_no_valid", nmv, 0);

      // Single frame then idle.
      trk_clr();
      for (int i = 0; i < 16; i++) cyc(1, 1, 300 + i, -300 - i);
      repeat (60) cyc(1, 0, 0, 0);
      chk("e_nvalid", nmv, 16);
      chk("e_nlast", nlast, 1);
      chk("e_busy_fall", busy_fall - last_mv, 2);

      // Randomized traffic with occasional resets and long gaps.
      for (int i = 0; i < 3000; i++) begin
         if ($urandom_range(0, 399) == 0) cyc(0, 1'($urandom_range(0, 1)), 0, 0);
         else if ($urandom_range(0, 99) == 0) repeat (30) cyc(1, 0, 0, 0);
         else cyc(1, $urandom_range(0, 9) < 8, int'($urandom), int'($urandom));
      end

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule

// File: doc/fft_r22sdf_ctrl.md
Name: fft_r22sdf_ctrl

Overview:
- Front-end sequencer for the single-path R2²SDF FFT pipeline.
- Accepts a valid/ready sample stream and drives the pipeline's free-running sample counter and input data, inserting zeros for gaps and drain.
- Tags every pipeline sample as real or filler, delays the tag by the pipeline latency, and produces output valid, bit-reversed bin index, last and error flags alongside the pipeline's z outputs.
- Sits between the ADC/stream source and the first butterfly stage.

Parameters:
- DATA_WIDTH, 25, sample width (real and imag each).
- FFT_N, 1024, points per frame.
- FFT_NLOG2, 10, log2(FFT_N).
- PIPE_LAT, 1033, cycles from a sample on pipe_*_o to its result on the pipeline outputs. Set by the top level; must be ≥ 1.

Ports:
- clk_i  in  1  clock
- rst_n  in  1  reset. Synchronous, active-low; clock clk_i.
- s_valid_i  in  1  input sample valid
- s_ready_o  out  1  input sample accepted when s_valid_i & s_ready_o
- s_re_i, s_im_i  in  DATA_WIDTH each  signed input sample
- pipe_cnt_o  out  FFT_NLOG2  sample counter to the first stage cnt_i
- pipe_re_o, pipe_im_o  out  DATA_WIDTH each  signed sample to the first stage
- m_valid_o  out  1  pipeline output holds a real FFT bin
- m_idx_o  out  FFT_NLOG2  natural-order bin index of the current output (bit-reversed output counter)
- m_last_o  out  1  final bin of a frame
- busy_o  out  1  state ≠ IDLE
- err_o  out  1  sticky: s_valid_i dropped mid-frame

Behaviour:
- Reset values:
  - pipe_cnt_o = 0, pipe_re_o = pipe_im_o = 0.
  - m_valid_o = 0, m_idx_o = 0, m_last_o = 0.
  - busy_o = 0, err_o = 0.
  - State IDLE, started = 0, tag line all 0, in_flight = 0, out_cnt = 0.
- Reset mid-operation discards all in-flight tags. No output valid appears until new input arrives.
- Counter rule:
  - Once started = 1, pipe_cnt_o increments every cycle, wrapping FFT_N-1 → 0, and never pauses until reset. Stage counters depend on this continuity.
  - Before the first start, pipe_cnt_o holds 0.
- All pipe_* outputs are registered: 1 cycle from accept to pipe_*_o.
- States:
  - IDLE:
    - Feeds zeros with tag 0.
    - s_ready_o = 1 if started = 0; otherwise only on cycles where the next pipe_cnt_o value is 0 (frame-aligned).
    - An accept goes to RUN, sets started, and presents the sample with count 0 and tag 1.
  - RUN:
    - s_ready_o = 1. Each cycle presents one sample with tag 1.
    - If s_valid_i = 0 at a nonzero frame position: present zero, tag 1, set err_o. The frame completes with zero fill.
    - If s_valid_i = 0 when the next position is 0: go to FLUSH and present zero, tag 0.
  - FLUSH:
    - s_ready_o = 0. Zeros with tag 0 are presented until in_flight = 0, then go to IDLE.
    - If in_flight is already 0 on entry, return to IDLE next cycle.
- Tag delay line:
  - Depth PIPE_LAT, aligned to pipe_*_o, so m_valid_o = the tag delayed PIPE_LAT cycles.
  - in_flight counts tags = 1 inside the line: +1 on entry, −1 on exit, both in one cycle → unchanged.
  - in_flight width is clog2(PIPE_LAT+1).
- Output indexing:
  - out_cnt increments on each m_valid_o and wraps at FFT_N.
  - m_idx_o = bit_reverse(out_cnt).
  - m_last_o = m_valid_o & (out_cnt == FFT_N-1).
  - Frames are contiguous within a RUN, so out_cnt stays frame-aligned. An IDLE gap leaves out_cnt at 0 because only whole frames are tagged.
- Back-to-back frames: RUN continues across boundaries while s_valid_i stays high at position 0. No bubbles.
- err_o is cleared only by reset.

Decomposition:
- Shared package fft_r22sdf_pkg holds:
  - State encoding (IDLE, RUN, FLUSH).
  - The bit-reverse function.
  - The clog2 helper.
- Natural sub-module: fft_r22sdf_tag_delay, a 1-bit PIPE_LAT-deep shift line built on the existing shift_reg. Outputs the delayed tag and maintains in_flight.

Test Plan (FFT_N=16, FFT_NLOG2=4, PIPE_LAT=20):
- Reset, then hold s_valid_i high for 32 samples (values 1..32), then drop it:
  - pipe_cnt_o reads 0..15, 0..15 starting the cycle after the first accept.
  - m_valid_o is high exactly on cycles 21..52 after the first accept.
  - m_idx_o follows 0, 8, 4, 12, …; m_last_o pulses twice.
  - busy_o falls one cycle after in_flight reaches 0.
- Drop s_valid_i for one cycle at frame position 5:
  - pipe_re_o = 0 at count 5, err_o rises and stays high.
  - m_valid_o is still high for 16 consecutive outputs of that frame.
- After a drained frame, raise s_valid_i at an arbitrary pipe_cnt_o = 7:
  - s_ready_o stays low until the cycle whose next count is 0; the first accepted sample appears with pipe_cnt_o = 0.
- Apply rst_n low mid-frame at count 9 with 10 tags in flight:
  - All outputs return to reset values, pipe_cnt_o = 0.
  - m_valid_o never rises without new input.
- Single frame of 16 samples then idle:
  - After the frame, pipe_re_o/pipe_im_o = 0 and state = FLUSH for 20 cycles, then IDLE.
  - pipe_cnt_o keeps counting throughout.
